int_widen_pipe: RTL

//  Pipelined integer-type normaliser. Takes a raw value tagged with its SV integer type and

---
 rtl/int_types_pkg.sv | 35 +++
 rtl/int_skid_buf.sv | 63 ++++++
 rtl/int_widen_pipe.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/int_types_pkg.sv
// Shared integer-type definitions for the widening pipe: type tags, native widths
// and the tag-to-width lookup used by the decode stage.
package int_types_pkg;

    localparam int unsigned KIND_W = 3;
    localparam int unsigned VW_W   = 7;
    localparam int unsigned MAX_VW = 64;

    // Width reported for an illegal tag; doubles as the error marker in decode.
    localparam logic [VW_W-1:0] ERR_WIDTH = VW_W'(0);

    typedef enum logic [KIND_W-1:0] {
        KIND_BYTE     = 3'd0,
        KIND_SHORTINT = 3'd1,
        KIND_INT      = 3'd2,
        KIND_LONGINT  = 3'd3,
        KIND_VEC      = 3'd4
    } kind_e;

    localparam logic [VW_W-1:0] KIND_WIDTH [4] = '{7'd8, 7'd16, 7'd32, 7'd64};

    function automatic logic [VW_W-1:0] width_of(input logic [KIND_W-1:0] kind,
                                                 input logic [VW_W-1:0]   vwidth);
        logic [VW_W-1:0] w;
        w = ERR_WIDTH;
        if (kind < KIND_W'(KIND_VEC)) begin
            w = KIND_WIDTH[kind[1:0]];
        end else if ((kind == KIND_W'(KIND_VEC)) && (vwidth != '0) &&
                     (vwidth <= VW_W'(MAX_VW))) begin
            w = vwidth;
        end
        return w;
    endfunction

endpackage

// File: rtl/int_skid_buf.sv
// Two-entry valid/ready skid buffer with registered outputs. A pop from a full
// buffer frees a slot for a push on the same edge.
module int_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready_c,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full_next_c
);

    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             out_valid_q;
    logic             push;
    logic             pop;

    assign pop        = out_valid_q && out_ready;
    assign in_ready_c = (count_q != 2'd2) || pop;
    assign push       = in_valid && in_ready_c;

    // Occupancy after this edge's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        full_next_c = (count_d == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= (count_d != 2'd0);
            if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                head_q <= in_data;
            end else if (pop && (count_q == 2'd2)) begin
                head_q <= tail_q;
            end
            if (push && (((count_q == 2'd1) && !pop) || (count_q == 2'd2))) begin
                tail_q <= in_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/int_widen_pipe.sv
// Pipelined integer-type normaliser: decode (width/mask/sign), extend to OUT_W,
// then a 2-entry output skid buffer with saturating transfer/error counters.
module int_widen_pipe
    import int_types_pkg::*;
#(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_kind,
    input  logic             in_signed,
    input  logic [6:0]       in_vwidth,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [6:0]       out_width,
    output logic             out_neg,
    output logic             out_err,
    output logic [CNT_W-1:0] xfer_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned PAY_W = OUT_W + VW_W + 2;

    logic             adv_c;
    logic             full_next_c;
    logic             in_ready_q;

    logic [VW_W-1:0]  dec_width;
    logic [IN_W-1:0]  dec_data;
    logic             dec_sign;

    logic             s1_valid;
    logic [VW_W-1:0]  s1_width;
    logic [IN_W-1:0]  s1_data;
    logic             s1_sign;
    logic             s1_signed;
    logic             s1_err;

    logic [OUT_W-1:0] s1_data_w;
    logic [OUT_W-1:0] ext_data;
    logic             ext_fill;

    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic [VW_W-1:0]  s2_width;
    logic             s2_neg;
    logic             s2_err;

    logic [PAY_W-1:0] buf_out;
    logic             pop;
    logic [CNT_W-1:0] xfer_count_q;
    logic [CNT_W-1:0] err_count_q;

    // Decode: width lookup, mask to width, pick the source MSB.
    always_comb begin
        dec_width = width_of(in_kind, in_vwidth);
        dec_data  = '0;
        dec_sign  = 1'b0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (i < int'(dec_width)) begin
                dec_data[i] = in_data[i];
            end
            if ((i + 1) == int'(dec_width)) begin
                dec_sign = in_data[i];
            end
        end
    end

    // The whole pipe advances whenever the buffer can take s2's entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_width  <= '0;
            s1_data   <= '0;
            s1_sign   <= 1'b0;
            s1_signed <= 1'b0;
            s1_err    <= 1'b0;
        end else if (adv_c) begin
            s1_valid  <= in_valid && in_ready_q;
            s1_width  <= dec_width;
            s1_data   <= dec_data;
            s1_sign   <= dec_sign;
            s1_signed <= in_signed;
            s1_err    <= (dec_width == ERR_WIDTH);
        end
    end

    // Extend: keep the low W bits, fill the rest with the effective sign.
    always_comb begin
        s1_data_w = OUT_W'(s1_data);
        ext_fill  = s1_signed & s1_sign;
        ext_data  = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            ext_data[i] = (i < int'(s1_width)) ? s1_data_w[i] : ext_fill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_width <= '0;
            s2_neg   <= 1'b0;
            s2_err   <= 1'b0;
        end else if (adv_c) begin
            s2_valid <= s1_valid;
            s2_data  <= ext_data;
            s2_width <= s1_width;
            s2_neg   <= ext_fill;
            s2_err   <= s1_err;
        end
    end

    int_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s2_valid),
        .in_ready_c (adv_c),
        .in_data    ({s2_data, s2_width, s2_neg, s2_err}),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (buf_out),
        .full_next_c(full_next_c)
    );

    assign {out_data, out_width, out_neg, out_err} = buf_out;

    // in_ready tracks post-edge buffer occupancy, so it never needs out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= !full_next_c;
        end
    end

    assign in_ready = in_ready_q;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= '0;
            err_count_q  <= '0;
        end else if (pop) begin
            if (xfer_count_q != '1) begin
                xfer_count_q <= xfer_count_q + CNT_W'(1);
            end
            if (out_err && (err_count_q != '1)) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end
        end
    end

    assign xfer_count = xfer_count_q;
    assign err_count  = err_count_q;

endmodule
